dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Synthesizable data-memory responder for the CPU data port: the slave end of the `mem_req/mem_we/mem_addr/mem_data/mem_sel` ↔ `mem_data_i/mem_valid_i/mem_ready_i` protocol.
- Serves one outstanding request at a time, with programmable latency.
- Byte-lane writes, little-endian word storage.
- Decodes an exit/halt MMIO address so FPGA and simulation runs can signal benchmark completion without a testbench.

Parameters:
- ADDR_WIDTH, 16, byte-address bits backed by RAM (2^ADDR_WIDTH bytes, stored as 2^(ADDR_WIDTH-2) 32-bit words).
- LATENCY, 2, cycles from request acceptance to completion; legal range 1..15.
- EXIT_ADDR, 32'h00030004, write-only halt register address.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_i  in  1  request valid; requester holds it until accepted
- we_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address
- wdata_i  in  32  write data, lane n = bits [8n+7:8n]
- sel_i  in  4  byte-lane enables for writes
- ready_o  out  1  responder can accept a request this cycle
- valid_o  out  1  read data valid, one-cycle pulse
- rdata_o  out  32  read data
- halt_o  out  1  sticky: EXIT_ADDR was written
- halt_code_o  out  32  data of the EXIT_ADDR write
- err_o  out  1  one-cycle pulse: out-of-range access completed

Behaviour:
- One clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, counter=0, valid_o=0, rdata_o=0, halt_o=0, halt_code_o=0, err_o=0.
- RAM contents are not affected by reset.
- ready_o is combinational: (state==IDLE) && !halt_o.

FSM states:
- IDLE: on a clock edge with req_i && ready_o, latch addr/we/wdata/sel, load counter=LATENCY-1, go to BUSY.
- BUSY: on each edge, if counter!=0, decrement it; if counter==0, complete the request and return to IDLE.
- req_i while ready_o=0 is ignored. The requester must hold req_i; there is no queueing.

Completion (the edge that leaves BUSY):
- Read, in range: rdata_o <= word at addr[ADDR_WIDTH-1:2], lanes assembled little-endian; valid_o <= 1 for exactly one cycle.
- Write, in range: for each n with sel[n]=1, byte lane n <= wdata[8n+7:8n]. Lanes with sel[n]=0 are untouched. valid_o is not pulsed; completion is signalled by ready_o reasserting.
- addr[1:0] is ignored. Accesses are word-indexed and sel selects lanes within the word.

Address decode, in priority order:
1. Write with addr == EXIT_ADDR: halt_o <= 1, halt_code_o <= wdata; RAM is not written.
2. addr[31:ADDR_WIDTH] != 0: err_o pulses for one cycle. A read returns rdata_o=0 with a valid_o pulse. A write is dropped.
3. Otherwise: normal RAM access.

Timing:
- Acceptance at edge E0 → completion at edge E_LATENCY. valid_o and ready_o are both high during the cycle after E_LATENCY.
- A back-to-back request can be accepted at edge E_LATENCY+1.
- rdata_o holds its value until the next read completion.

Halt and reset:
- halt_o is sticky until rst. After halt, ready_o stays 0 and further requests are never accepted.
- rst mid-BUSY: the transaction is aborted, a pending write is not committed, and valid_o never pulses.
- A single outstanding request means there are no read-after-write hazards inside the block.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outputs read 0 immediately; ready_o=1 after release.
- LATENCY=2 write: write 0xDEADBEEF, sel=4'hF, to 0x100, then read 0x100 → valid_o pulses 2 edges after read acceptance, rdata_o=0xDEADBEEF; no valid_o pulse on the write.
- Byte lanes: after the previous write, write 0x0000AA00 with sel=4'b0010 to 0x102, then read 0x100 → 0xDEADAAEF (addr[1:0] ignored).
- Out of range (ADDR_WIDTH=16): read 0x00020000 → err_o and valid_o pulse in the same cycle, rdata_o=0. Write to the same address → err_o pulses, RAM unchanged.
- Exit register: write 5 to 0x00030004 → halt_o=1, halt_code_o=5; ready_o stays 0 for 20 further cycles despite req_i=1.
- Reset mid-operation (LATENCY=4): write 0x12345678 to 0x200, assert rst after 2 cycles, then read 0x200 → old contents returned; valid_o never pulsed for the aborted request.

Source files
------------

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-outstanding data-memory responder with programmable
//            latency, byte-lane writes and an exit/halt MMIO register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] EXIT_ADDR  = 32'h0003_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        halt_o,
  output logic [31:0] halt_code_o,
  output logic        err_o
);

  localparam int         c_words  = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_busy = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [3:0]            r_cnt;
  logic [31:0]           r_addr;
  logic                  r_we;
  logic [31:0]           r_wdata;
  logic [3:0]            r_sel;
  logic [31:0]           r_mem [c_words];

  logic                  w_accept;
  logic                  w_done;
  logic                  w_exit;
  logic                  w_oor;
  logic                  w_ram_wr;
  logic [ADDR_WIDTH-3:0] w_word;

  // State register, countdown and request capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
      r_sel   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= c_lat_m1;
        r_addr  <= addr_i;
        r_we    <= we_i;
        r_wdata <= wdata_i;
        r_sel   <= sel_i;
      end else if (r_state == c_st_busy && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_nxt = c_st_busy;
      c_st_busy: if (r_cnt == 4'd0) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Handshake and completion decode
  always_comb begin
    ready_o  = (r_state == c_st_idle) && !halt_o;
    w_accept = req_i && ready_o;
    w_done   = (r_state == c_st_busy) && (r_cnt == 4'd0);
    w_exit   = r_we && (r_addr == EXIT_ADDR);
    w_oor    = (r_addr >> ADDR_WIDTH) != 32'd0;
    w_ram_wr = w_done && r_we && !w_exit && !w_oor && !rst;
    w_word   = r_addr[ADDR_WIDTH-1:2];
  end

  // RAM is deliberately outside the reset domain so contents survive rst
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int n = 0; n < 4; n++) begin
        if (r_sel[n]) r_mem[w_word][8*n +: 8] <= r_wdata[8*n +: 8];
      end
    end
  end

  // Response outputs; exit decode takes priority over the range check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o     <= 1'b0;
      rdata_o     <= 32'd0;
      halt_o      <= 1'b0;
      halt_code_o <= 32'd0;
      err_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (w_done) begin
        if (w_exit) begin
          halt_o      <= 1'b1;
          halt_code_o <= r_wdata;
        end else if (w_oor) begin
          err_o <= 1'b1;
          if (!r_we) begin
            valid_o <= 1'b1;
            rdata_o <= 32'd0;
          end
        end else if (!r_we) begin
          valid_o <= 1'b1;
          rdata_o <= r_mem[w_word];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Scoreboard bench for dmem_responder with a word-array model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int          LAT  = 2;
  localparam logic [31:0] EXIT = 32'h0003_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [3:0]  sel_i = 4'd0;
  logic        ready_o, valid_o, halt_o, err_o;
  logic [31:0] rdata_o, halt_code_o;

  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(LAT), .EXIT_ADDR(EXIT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .sel_i(sel_i), .ready_o(ready_o), .valid_o(valid_o),
    .rdata_o(rdata_o), .halt_o(halt_o), .halt_code_o(halt_code_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        valid;
    logic        err;
    logic [31:0] data;
    int          when;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] model [int];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid/err pulse must match the oldest expected response
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (valid_o || err_o)) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: valid=%b err=%b rdata=%h", valid_o, err_o, rdata_o);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("resp_cycle", cyc, e.when);
          check("resp_valid", {31'd0, valid_o}, {31'd0, e.valid});
          check("resp_err", {31'd0, err_o}, {31'd0, e.err});
          if (e.valid) check("resp_rdata", rdata_o, e.data);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request and record its expected effect in the model/scoreboard
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel);
    int   acc;
    int   w;
    logic oor;
    exp_t e;
    @(negedge clk);
    wait_ready();
    if (!ready_o) return;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; sel_i = sel;
    acc = cyc + 1;
    w   = int'(addr[15:2]);
    oor = (addr >> 16) != 32'd0;
    if (we && addr == EXIT) begin
      // halt: no response pulse, RAM untouched
    end else if (oor) begin
      e.valid = !we; e.err = 1'b1; e.data = 32'd0; e.when = acc + LAT;
      expq.push_back(e);
    end else if (we) begin
      logic [31:0] old;
      old = model.exists(w) ? model[w] : 32'd0;
      for (int n = 0; n < 4; n++)
        if (sel[n]) old[8*n +: 8] = wdata[8*n +: 8];
      model[w] = old;
    end else begin
      e.valid = 1'b1; e.err = 1'b0; e.data = model[w]; e.when = acc + LAT;
      expq.push_back(e);
    end
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    check({tag, "_halt"}, {31'd0, halt_o}, 32'd0);
    check({tag, "_halt_code"}, halt_code_o, 32'd0);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    check_zero_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    check("por_ready", {31'd0, ready_o}, 32'd1);

    // Directed: full write, read, byte-lane merge, misaligned address
    do_req(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF);
    do_req(1'b1, 32'h0000_0200, 32'hCAFE_0200, 4'hF);
    do_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    do_req(1'b0, 32'h0000_0100, 32'd0, 4'h0);
    do_req(1'b1, 32'h0000_0102, 32'h0000_AA00, 4'b0010);
    do_req(1'b0, 32'h0000_0100, 32'd0, 4'h0);
    repeat (LAT + 1) @(negedge clk);
    check("lane_merge_literal", rdata_o, 32'hDEAD_AAEF);

    // Out of range: read returns 0 with err; write is dropped
    do_req(1'b0, 32'h0002_0000, 32'd0, 4'h0);
    do_req(1'b1, 32'h0002_0000, 32'h1111_2222, 4'hF);
    do_req(1'b0, 32'h0000_0000, 32'd0, 4'h0);

    // Randomized traffic over a pool of pre-initialised words
    for (int i = 0; i < 16; i++)
      do_req(1'b1, 32'h400 + 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) begin
        a = (32'($urandom_range(1, 255)) << 16) | 32'($urandom_range(0, 65535));
        if (a == EXIT) a = a ^ 32'h0000_0100;
      end else begin
        a = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      end
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-cycle clears outputs immediately
    do_req(1'b0, 32'h0000_0100, 32'd0, 4'h0);
    repeat (LAT + 1) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {31'd0, ready_o}, 32'd1);

    // Reset while a write is in flight: write must not commit
    wait_ready();
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h200; wdata_i = 32'h1234_5678; sel_i = 4'hF;
    @(negedge clk);
    req_i = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 32'h0000_0200, 32'd0, 4'h0);
    repeat (LAT + 1) @(negedge clk);
    check("abort_old_data", rdata_o, 32'hCAFE_0200);

    // Exit register: sticky halt, requests never accepted afterwards
    do_req(1'b1, EXIT, 32'd5, 4'hF);
    repeat (LAT) @(negedge clk);
    check("halt", {31'd0, halt_o}, 32'd1);
    check("halt_code", halt_code_o, 32'd5);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_ready_low", {31'd0, ready_o}, 32'd0);
    end
    req_i = 1'b0;
    check("halt_sticky", {31'd0, halt_o}, 32'd1);
    rst = 1'b1;
    #1 check("halt_cleared", {31'd0, halt_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    repeat (5) @(negedge clk);
    check("pending_responses", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
